// File: rtl/circuit_2.sv
// Clocked 3-input programmable Boolean cell: y = tt[{a,b,c}], plus a registered copy.
// Optional macro CIRCUIT_2_STATS_EN builds a saturating counter of cycles with y_q=1.
module circuit_2 #(
  parameter logic [7:0] TT_INIT = 8'hE8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        tt_we,
  input  logic [7:0]  tt_wdata,
  output logic        y,
  output logic        y_q,
  output logic [7:0]  tt,
  output logic [15:0] ones_cnt
);

  logic [7:0] tt_q, tt_d;
  logic       yReg_q, yReg_d;
  logic [2:0] tableIdx;

  assign tableIdx = {a, b, c};

  // y always reads the table as registered before the edge, so a same-cycle write is invisible
  always_comb begin
    y      = tt_q[tableIdx];
    tt_d   = tt_q;
    yReg_d = y;
    if (tt_we) begin
      tt_d = tt_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tt_q   <= TT_INIT;
      yReg_q <= 1'b0;
    end else begin
      tt_q   <= tt_d;
      yReg_q <= yReg_d;
    end
  end

  assign tt  = tt_q;
  assign y_q = yReg_q;

`ifdef CIRCUIT_2_STATS_EN
  logic [15:0] onesCnt_q, onesCnt_d;

  // Counts on the pre-edge y_q and holds at all-ones instead of wrapping
  always_comb begin
    onesCnt_d = onesCnt_q;
    if (yReg_q && (onesCnt_q != 16'hFFFF)) begin
      onesCnt_d = onesCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      onesCnt_q <= 16'h0000;
    end else begin
      onesCnt_q <= onesCnt_d;
    end
  end

  assign ones_cnt = onesCnt_q;
`else
  assign ones_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_circuit_2.sv
// Directed self-checking bench for circuit_2 (truth table, registered output, optional stats counter).
module tb_circuit_2;

  logic        clk;
  logic        rst;
  logic        a, b, c;
  logic        tt_we;
  logic [7:0]  tt_wdata;
  logic        y;
  logic        y_q;
  logic [7:0]  tt;
  logic [15:0] ones_cnt;

  int testsRun    = 0;
  int testsFailed = 0;

  circuit_2 dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .c        (c),
    .tt_we    (tt_we),
    .tt_wdata (tt_wdata),
    .y        (y),
    .y_q      (y_q),
    .tt       (tt),
    .ones_cnt (ones_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tt_we = 1'b0;
    tt_wdata = 8'h00;
    {a, b, c} = 3'b000;
    tick();
    tick();
    rst = 1'b0;
    testsRun++;
    if (tt !== 8'hE8) begin
      testsFailed++;
      $display("[TB] FAIL reset_tt: got %h expected e8", tt);
    end
    testsRun++;
    if (y_q !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_yq: got %b expected 0", y_q);
    end
    testsRun++;
    if (ones_cnt !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_cnt: got %h expected 0000", ones_cnt);
    end
  endtask

  // Sweep abc 000..111, checking y immediately and y_q after the following edge
  task automatic test_sweep(input logic [7:0] expVec, input string tag);
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      #1;
      testsRun++;
      if (y !== expVec[i]) begin
        testsFailed++;
        $display("[TB] FAIL %s_y[%0d]: got %b expected %b", tag, i, y, expVec[i]);
      end
      tick();
      testsRun++;
      if (y_q !== expVec[i]) begin
        testsFailed++;
        $display("[TB] FAIL %s_yq[%0d]: got %b expected %b", tag, i, y_q, expVec[i]);
      end
    end
  endtask

  task automatic test_majority();
    test_sweep(8'b1110_1000, "maj");
  endtask

  task automatic test_table_load();
    tt_we = 1'b1;
    tt_wdata = 8'h96;
    tick();
    tt_we = 1'b0;
    tt_wdata = 8'h00;
    testsRun++;
    if (tt !== 8'h96) begin
      testsFailed++;
      $display("[TB] FAIL load_tt: got %h expected 96", tt);
    end
    test_sweep(8'b1001_0110, "par");
  endtask

  task automatic test_write_coincide();
    test_reset();
    {a, b, c} = 3'b011;
    #1;
    testsRun++;
    if (y !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL coin_y_pre: got %b expected 1", y);
    end
    tt_we = 1'b1;
    tt_wdata = 8'h00;
    #1;
    testsRun++;
    if (y !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL coin_y_same: got %b expected 1", y);
    end
    tick();
    tt_we = 1'b0;
    testsRun++;
    if (y_q !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL coin_yq_edge1: got %b expected 1", y_q);
    end
    testsRun++;
    if (y !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL coin_y_after: got %b expected 0", y);
    end
    tick();
    testsRun++;
    if (y_q !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL coin_yq_edge2: got %b expected 0", y_q);
    end
  endtask

  task automatic test_reset_priority();
    {a, b, c} = 3'b111;
    tt_we = 1'b1;
    tt_wdata = 8'hFF;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tt_we = 1'b0;
    testsRun++;
    if (tt !== 8'hE8) begin
      testsFailed++;
      $display("[TB] FAIL rstpri_tt: got %h expected e8", tt);
    end
    testsRun++;
    if (y_q !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rstpri_yq: got %b expected 0", y_q);
    end
    testsRun++;
    if (ones_cnt !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL rstpri_cnt: got %h expected 0000", ones_cnt);
    end
  endtask

  task automatic test_stats();
    logic [15:0] expFive;
    logic [15:0] expSat;
    logic [15:0] expIdle;
`ifdef CIRCUIT_2_STATS_EN
    expFive = 16'd4;
    expSat  = 16'hFFFF;
    expIdle = 16'd0;
`else
    expFive = 16'd0;
    expSat  = 16'd0;
    expIdle = 16'd0;
`endif
    test_reset();
    {a, b, c} = 3'b000;
    for (int i = 0; i < 3; i++) tick();
    testsRun++;
    if (ones_cnt !== expIdle) begin
      testsFailed++;
      $display("[TB] FAIL stats_idle: got %h expected %h", ones_cnt, expIdle);
    end
    test_reset();
    {a, b, c} = 3'b111;
    for (int i = 0; i < 5; i++) tick();
    testsRun++;
    if (ones_cnt !== expFive) begin
      testsFailed++;
      $display("[TB] FAIL stats_five: got %h expected %h", ones_cnt, expFive);
    end
    for (int i = 0; i < 70000; i++) tick();
    testsRun++;
    if (ones_cnt !== expSat) begin
      testsFailed++;
      $display("[TB] FAIL stats_sat: got %h expected %h", ones_cnt, expSat);
    end
    for (int i = 0; i < 4; i++) tick();
    testsRun++;
    if (ones_cnt !== expSat) begin
      testsFailed++;
      $display("[TB] FAIL stats_hold: got %h expected %h", ones_cnt, expSat);
    end
  endtask

  initial begin
    rst = 1'b1;
    tt_we = 1'b0;
    tt_wdata = 8'h00;
    {a, b, c} = 3'b000;
    @(negedge clk);
    test_reset();
    test_majority();
    test_table_load();
    test_write_coincide();
    test_reset_priority();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/circuit_2.md
Name: circuit_2

Overview:
- Clocked 3-input Boolean function unit.
- Output y is a programmable function of inputs a, b, c, selected from an 8-entry truth table.
- Provides a combinational result and a registered result; used as a small configurable glue-logic cell in combinational-circuit exercises.
- Default function is 3-input majority.

Parameters:
- TT_INIT, 8'hE8, reset value of the truth table; bit index = {a,b,c}; default = majority(a,b,c).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- a  input  1  function input, MSB of table index.
- b  input  1  function input, middle bit of table index.
- c  input  1  function input, LSB of table index.
- tt_we  input  1  truth-table write enable.
- tt_wdata  input  8  new truth table, loaded when tt_we=1.
- y  output  1  combinational result = tt[{a,b,c}].
- y_q  output  1  registered copy of y, one-cycle latency.
- tt  output  8  current truth-table contents.
- ones_cnt  output  16  count of cycles with y_q=1 (see Optional Feature).

Behaviour:
- Reset, synchronous: on a rising clk edge with rst=1:
  - tt <= TT_INIT
  - y_q <= 0
  - ones_cnt <= 0
- rst has priority over tt_we in the same cycle; the write is discarded.
- Table load: at a rising edge with rst=0 and tt_we=1, tt <= tt_wdata. tt holds its value otherwise.
- y is purely combinational: y = tt[{a,b,c}], where index 0 = a0b0c0 and index 7 = a1b1c1.
  - y follows a/b/c changes with zero cycle latency and no clock dependency.
  - y uses the currently registered tt value. A tt_we in the current cycle affects y only after the edge.
- y_q: at each rising edge with rst=0, y_q <= y, evaluated with the pre-edge tt.
  - When tt_we and an input change coincide, y_q captures the old-table result; the new table appears in y_q one cycle later.
- Default TT_INIT=8'hE8 gives y=1 for abc in {011,101,110,111} and y=0 otherwise.
- X/Z on a/b/c is not supported. Inputs are assumed driven 0/1.
- There are no handshakes and no state machine beyond the tt, y_q and ones_cnt registers.

Optional Feature:
- Macro: CIRCUIT_2_STATS_EN.
- Defined:
  - ones_cnt is a 16-bit counter incrementing by 1 at every rising edge (rst=0) where the pre-edge y_q=1.
  - It saturates at 16'hFFFF and does not wrap.
  - It is cleared by rst.
- Not defined:
  - No counter logic is built.
  - ones_cnt is tied to 16'h0000. Port list is unchanged.

Test Plan:
- Reset with TT_INIT default, then sweep abc 000..111 in 10 ns steps. Required y sequence: 0,0,0,1,0,1,1,1 (majority). y_q matches y one clk later. After reset, tt=8'hE8 and y_q=0.
- Write tt_wdata=8'h96 with tt_we=1 for one cycle, then sweep abc 000..111. Required y = parity: 0,1,1,0,1,0,0,1. tt reads 8'h96.
- Hold abc=011 with y=1 under TT=E8, and assert tt_we with tt_wdata=8'h00 in the same cycle:
  - Edge 1: y_q=1 (old table).
  - After edge 1: y=0.
  - Edge 2: y_q=0.
- Assert rst=1 and tt_we=1 (tt_wdata=8'hFF) in the same cycle. Required after edge: tt=8'hE8, y_q=0, ones_cnt=0.
- With CIRCUIT_2_STATS_EN and abc=111 held for 5 cycles after reset: ones_cnt=4 after the 5th edge (y_q lags by one cycle).
  - With the counter forced near the limit (abc=111 held 70000 cycles): ones_cnt=16'hFFFF and stays there.
  - Without the macro: ones_cnt=0 throughout.
